// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer taking two-word icache groups and presenting two entries to decode.
// Optional macro FETCH_QUEUE_EXCP_EN stores and drives a per-entry fetch exception tag.
module fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_mask,
  input  logic        in_excp,
  output logic [1:0]  out_valid,
  output logic [31:0] out0_inst,
  output logic [31:0] out1_inst,
  output logic [31:0] out0_pc,
  output logic [31:0] out1_pc,
  output logic        out0_excp,
  output logic        out1_excp,
  input  logic [1:0]  out_accept
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t READY_MAX = cnt_t'(DEPTH - 2);

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  ptr_t head;
  ptr_t tail;
  cnt_t count;

  ptr_t head_p1;
  ptr_t tail_p1;

  logic        push_en;
  logic        wr0_en;
  logic        wr1_en;
  logic [31:0] wr0_inst;
  logic [31:0] wr0_pc;
  logic [31:0] wr1_inst;
  logic [31:0] wr1_pc;
  cnt_t        n_push;

  logic pop0;
  logic pop1;
  cnt_t n_pop;

  assign head_p1 = head + ptr_t'(1);
  assign tail_p1 = tail + ptr_t'(1);

  // Ready depends only on the registered count so a full group always fits.
  assign in_ready  = (count <= READY_MAX);
  assign out_valid = {(count >= cnt_t'(2)), (count >= cnt_t'(1))};

  assign push_en = in_valid && in_ready && !flush;

  always_comb begin
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_inst = '0;
    wr0_pc   = '0;
    wr1_inst = '0;
    wr1_pc   = '0;
    n_push   = '0;
    if (push_en) begin
      unique case (in_mask)
        2'b11: begin
          wr0_en   = 1'b1;
          wr0_inst = in_data[31:0];
          wr0_pc   = in_pc;
          wr1_en   = 1'b1;
          wr1_inst = in_data[63:32];
          wr1_pc   = in_pc + 32'd4;
          n_push   = cnt_t'(2);
        end
        2'b01: begin
          wr0_en   = 1'b1;
          wr0_inst = in_data[31:0];
          wr0_pc   = in_pc;
          n_push   = cnt_t'(1);
        end
        // A lone high word still goes to the tail slot, packed without a gap.
        2'b10: begin
          wr0_en   = 1'b1;
          wr0_inst = in_data[63:32];
          wr0_pc   = in_pc + 32'd4;
          n_push   = cnt_t'(1);
        end
        default: begin
          n_push = '0;
        end
      endcase
    end
  end

  // Accept is thermometer-coded: the second entry pops only alongside the first.
  assign pop0  = out_accept[0] & out_valid[0];
  assign pop1  = pop0 & out_accept[1] & out_valid[1];
  assign n_pop = cnt_t'(pop0) + cnt_t'(pop1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(n_pop);
      tail  <= tail + ptr_t'(n_push);
      count <= count + n_push - n_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) begin
      inst_mem[tail] <= wr0_inst;
      pc_mem[tail]   <= wr0_pc;
    end
    if (wr1_en) begin
      inst_mem[tail_p1] <= wr1_inst;
      pc_mem[tail_p1]   <= wr1_pc;
    end
  end

  assign out0_inst = inst_mem[head];
  assign out1_inst = inst_mem[head_p1];
  assign out0_pc   = pc_mem[head];
  assign out1_pc   = pc_mem[head_p1];

`ifdef FETCH_QUEUE_EXCP_EN
  logic excp_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr0_en) excp_mem[tail]    <= in_excp;
    if (wr1_en) excp_mem[tail_p1] <= in_excp;
  end

  assign out0_excp = excp_mem[head];
  assign out1_excp = excp_mem[head_p1];
`else
  logic unused_in_excp;
  assign unused_in_excp = in_excp;
  assign out0_excp      = 1'b0;
  assign out1_excp      = 1'b0;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of 32-bit instruction entries (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  discard all queued and incoming entries.
REQ-005 SHALL have port in_valid  input  1  icache returns a fetch group this cycle.
REQ-006 SHALL have port in_ready  output  1  queue can accept a two-instruction group.
REQ-007 SHALL have port in_pc  input  32  8-byte-aligned group address (in_pc[2:0]=0).
REQ-008 SHALL have port in_data  input  64  icache rdata; [31:0] at in_pc, [63:32] at in_pc+4.
REQ-009 SHALL have port in_mask  input  2  per-word valid; bit0 low word, bit1 high word.
REQ-010 SHALL have port in_excp  input  1  fetch exception tag for the whole group.
REQ-011 SHALL have port out_valid  output  2  bit0: head entry valid; bit1: second entry valid.
REQ-012 SHALL have ports out0_inst/out1_inst  output  32 each  head / second instruction.
REQ-013 SHALL have ports out0_pc/out1_pc  output  32 each  PCs of those instructions.
REQ-014 SHALL have ports out0_excp/out1_excp  output  1 each  exception tags.
REQ-015 SHALL have port out_accept  input  2  decode consumes entries; thermometer (01, 11) only.

Function
REQ-016 SHALL be a circular buffer: head pointer, tail pointer (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits).
REQ-017 in_ready SHALL be (count <= DEPTH-2), from registered count only; no combinational path from out_accept or in_valid.
REQ-018 Push occurs when in_valid && in_ready && !flush; words written at tail in address order, skipping masked-off words.
REQ-019 Mask 11 -> 2 entries (in_pc, in_pc+4); 01 -> 1 entry (in_pc); 10 -> 1 entry (in_pc+4); 00 -> none, state unchanged.
REQ-020 Each pushed entry SHALL store in_excp.
REQ-021 out_valid[0] = (count >= 1), out_valid[1] = (count >= 2); out0 = entry[head], out1 = entry[head+1 mod DEPTH].
REQ-022 Pop count = popcount(out_accept & out_valid); bits above out_valid SHALL be ignored; 10 SHALL be treated as 00.
REQ-023 Same-cycle push and pop: count_next = count + pushed - popped; both pointers advance independently.
REQ-024 Outputs combinational from registered state only; zero-latency: entry pushed in cycle N visible at out in cycle N+1.
REQ-025 flush SHALL win over push and pop: next cycle count=0, head=tail=0, out_valid=00; in-flight group dropped.
REQ-026 Full: count=DEPTH-1 or DEPTH gives in_ready=0; in_valid SHALL then cause no state change.
REQ-027 Storage array SHALL not be reset; out data when invalid is don't-care.

Reset
REQ-028 On reset assertion, asynchronously: count=0, head=0, tail=0; therefore out_valid=00, in_ready=1.
REQ-029 Reset mid-operation SHALL discard all entries; first push after deassertion lands at index 0.

Configuration
REQ-030 Macro FETCH_QUEUE_EXCP_EN: defined -> per-entry exception bit stored and driven on out0_excp/out1_excp.
REQ-031 Without FETCH_QUEUE_EXCP_EN: no exception storage, in_excp ignored, out0_excp=out1_excp=0 constantly.

Verification
REQ-032 Reset, push pc=0x1c000000 data=0x0000_0002_0000_0001 mask=11 -> next cycle out_valid=11, out0_inst=1 pc 0x1c000000, out1_inst=2 pc 0x1c000004.
REQ-033 Push pc=0x1c000008 mask=10 -> single entry, out0_pc=0x1c00000c, out_valid=01.
REQ-034 Push 11 x4 with no accept (DEPTH=8) -> in_ready drops after count=8, 5th group ignored; accept 11 then count=6, in_ready=1.
REQ-035 Count=7, push mask=11 would overflow: in_ready=0 (7 > 6) -> no write; same cycle accept 01 -> count=6.
REQ-036 Count=5, push 11 with accept 11 and flush=1 -> next cycle count=0, out_valid=00; wrap test: 20 push/pop cycles, PCs emerge in order across index 7->0.
REQ-037 EXCP_EN defined: push in_excp=1 mask=11 -> out0_excp=out1_excp=1; macro undefined -> both 0.
